bulk_memory_controller: RTL and testbench
=========================================

Name: bulk_memory_controller

Overview:
Line-granular backing-memory controller that sits directly downstream of the instruction/data bulk request arbiter and terminates its master-side line requests.
Each accepted line read or write is serialised into LINE_SIZE word accesses on a single-port, word-wide synchronous SRAM with 1-cycle read latency.
For reads, the full line is reassembled and returned with a one-cycle resp_valid pulse. For writes, a one-cycle resp_valid acknowledge is returned.
Ports are listed flat; in RTL the req_*/resp_* group is a bulk_read_interface.slave modport, and that interface's dumping_cache is ignored.

Parameters:
DATA_W, 64, word width in bits (power of two, >=8)
ADDR_W, 64, byte address width of requests
LINE_SIZE, 16, words per line (power of two, >=2)
SRAM_ADDR_W, 12, word address width of backing SRAM (depth 2^SRAM_ADDR_W words)

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  1  line request valid
req_ready  out  1  controller can accept a request
req_addr  in  ADDR_W  byte address, any byte within the line
req_write  in  1  1=line write, 0=line read
req_wdata  in  LINE_SIZE x DATA_W  write line, element k = word k
req_wstrb  in  LINE_SIZE x DATA_W/8  byte strobes per word
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  LINE_SIZE x DATA_W  read line, element k = word k
sram_en  out  1  SRAM access enable
sram_we  out  1  SRAM write enable
sram_addr  out  SRAM_ADDR_W  SRAM word address
sram_wdata  out  DATA_W  SRAM write data
sram_wstrb  out  DATA_W/8  SRAM byte write strobes
sram_rdata  in  DATA_W  SRAM read data, valid the cycle after an en&&!we access

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock.
  - State goes to IDLE.
  - req_ready=1 in the first cycle after reset.
  - resp_valid=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, sram_wstrb=0, resp_rdata=0.
  - All latched request fields are cleared.
- Geometry: OFFSET_W = log2(LINE_SIZE) + log2(DATA_W/8).
  - Line base word = req_addr[OFFSET_W-1+... ] with the byte offset dropped: req_addr >> log2(DATA_W/8), low log2(LINE_SIZE) bits cleared.
  - Truncate to SRAM_ADDR_W; upper address bits are ignored, so the memory wraps modulo its depth.
- Word address for beat k = line base word + k, with k in 0..LINE_SIZE-1.
- FSM states: IDLE, ISSUE, DRAIN, RESPOND.
  - IDLE: req_ready=1.
    - On req_valid && req_ready, latch addr/write/wdata/wstrb and go to ISSUE with beat counter=0.
    - sram_en=0 in IDLE.
  - ISSUE: req_ready=0. Each cycle drive sram_en=1, sram_addr=base+beat.
    - Write: sram_we = |wstrb[beat], sram_wdata = wdata[beat], sram_wstrb = wstrb[beat].
    - Read: sram_we=0, sram_wstrb=0.
    - Beat increments each cycle, and the beat counter never wraps within a request.
    - Exit on beat==LINE_SIZE-1: go to DRAIN for a read, RESPOND for a write.
  - DRAIN (read only): sram_en=0, captures the final word, then goes to RESPOND.
  - RESPOND: resp_valid=1 for exactly one cycle, req_ready=0, then go to IDLE.
- Read capture: sram_rdata in the cycle after beat k is issued is written to resp_rdata[k].
- resp_rdata holding:
  - resp_rdata holds its value from RESPOND until the next read's capture begins.
  - Writes do not modify resp_rdata.
- Latency (accept in cycle T):
  - Read: resp_valid in T+LINE_SIZE+2.
  - Write: resp_valid in T+LINE_SIZE+1.
  - The earliest next accept is the cycle after RESPOND.
- Fixed-latency write rules:
  - A write beat with all-zero strobes still consumes its cycle, with sram_en=1, sram_we=0.
  - That beat leaves the SRAM word unchanged.
- Request inputs are sampled only at the accept edge; changes after accept have no effect.
- Only one request is outstanding at a time; no request is lost or duplicated.
- Reset mid-operation: the in-flight request is dropped, with no resp_valid and no further SRAM writes after the reset edge.
  - Writes already issued before reset remain in SRAM.

Test Plan:
- Read of a preloaded line: SRAM words 0x20..0x2F = 0xA000+i; read req_addr=0x100 → resp_valid exactly 18 cycles after accept, resp_rdata[k]=0xA000+k, sram_addr sequence 0x20..0x2F.
- Unaligned address: read req_addr=0x13F → same base 0x20 and identical data; also check upper-bit wrap: req_addr = 0x8000_0100 → sram_addr base 0x20.
- Write with strobes: write req_addr=0x80, wdata[k]=0x1111_1111_1111_1111*k, wstrb[k]=0xFF except wstrb[3]=0x00 and wstrb[5]=0x0F → resp_valid 17 cycles after accept; beat 3 has sram_we=0; readback shows word 3 unchanged and word 5 low 4 bytes updated only.
- Back-to-back handshake: req_valid held high with two reads → req_ready=0 from accept+1 through RESPOND, second accept in the cycle after the first resp_valid, exactly two resp_valid pulses; resp_rdata stable between them until the second capture.
- Input stability: change req_addr/req_wdata in the cycle after accept → SRAM traffic and response reflect the latched values only.
- Reset mid-read at beat 7 and mid-write at beat 7 → no resp_valid, req_ready=1 the cycle after reset; for the write, words 0..6 are written and words 7..15 are untouched.

Source files
------------

// File: rtl/bulk_memory_controller.sv
// Line-granular backing-memory controller: serialises each line request into
// LINE_SIZE single-word accesses on a 1-cycle-latency synchronous SRAM and
// returns the reassembled line (read) or an acknowledge (write).
module bulk_memory_controller #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned LINE_SIZE   = 16,
  parameter int unsigned SRAM_ADDR_W = 12
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [ADDR_W-1:0]                     req_addr,
  input  logic                                  req_write,
  input  logic [LINE_SIZE-1:0][DATA_W-1:0]      req_wdata,
  input  logic [LINE_SIZE-1:0][DATA_W/8-1:0]    req_wstrb,
  output logic                                  resp_valid,
  output logic [LINE_SIZE-1:0][DATA_W-1:0]      resp_rdata,
  output logic                                  sram_en,
  output logic                                  sram_we,
  output logic [SRAM_ADDR_W-1:0]                sram_addr,
  output logic [DATA_W-1:0]                     sram_wdata,
  output logic [DATA_W/8-1:0]                   sram_wstrb,
  input  logic [DATA_W-1:0]                     sram_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned BEAT_W = $clog2(LINE_SIZE);
  localparam int unsigned BYTE_W = $clog2(STRB_W);
  localparam int unsigned LINE_W = SRAM_ADDR_W - BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_RESPOND
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [BEAT_W-1:0]                r_beat;
  logic [LINE_W-1:0]                r_line;
  logic                             r_write;
  logic [LINE_SIZE-1:0][DATA_W-1:0] r_wdata;
  logic [LINE_SIZE-1:0][STRB_W-1:0] r_wstrb;
  logic                             r_cap_en;
  logic [BEAT_W-1:0]                r_cap_idx;
  logic [LINE_SIZE-1:0][DATA_W-1:0] r_rdata;

  logic                             w_accept;
  logic                             w_last;
  logic [LINE_W-1:0]                w_req_line;

  // Line index in SRAM words: byte and word-in-line offsets dropped, upper
  // address bits discarded so the memory wraps modulo its depth.
  assign w_req_line = LINE_W'(req_addr >> (BYTE_W + BEAT_W));
  assign w_last     = (r_beat == LAST_BEAT);
  assign resp_rdata = r_rdata;

  // State register, request latch and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_line  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_line  <= w_req_line;
        r_write <= req_write;
        r_wdata <= req_wdata;
        r_wstrb <= req_wstrb;
        r_beat  <= '0;
      end else if (r_state == S_ISSUE && !w_last) begin
        r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

  // Read capture: the word issued last cycle arrives now and lands in its slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_en  <= 1'b0;
      r_cap_idx <= '0;
      r_rdata   <= '0;
    end else begin
      r_cap_en  <= (r_state == S_ISSUE) && !r_write;
      r_cap_idx <= r_beat;
      if (r_cap_en) begin
        r_rdata[r_cap_idx] <= sram_rdata;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    sram_en     = 1'b0;
    sram_we     = 1'b0;
    sram_addr   = '0;
    sram_wdata  = '0;
    sram_wstrb  = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        sram_en   = 1'b1;
        sram_addr = {r_line, r_beat};
        if (r_write) begin
          // All-zero strobe beat still occupies its slot but must not write.
          sram_we    = |r_wstrb[r_beat];
          sram_wdata = r_wdata[r_beat];
          sram_wstrb = r_wstrb[r_beat];
        end
        if (w_last) begin
          w_state_nxt = r_write ? S_RESPOND : S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_RESPOND;
      end
      S_RESPOND: begin
        resp_valid  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Reset is synchronous, so the SRAM would otherwise still commit the beat
    // presented in the reset cycle; squash all traffic while rst is high.
    if (rst) begin
      w_accept   = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      sram_wstrb = '0;
    end
  end

endmodule

// File: tb/tb_bulk_memory_controller.sv
// Directed bench for bulk_memory_controller with a behavioural 1-cycle SRAM.
module tb_bulk_memory_controller;

  localparam int unsigned DW  = 64;
  localparam int unsigned AW  = 64;
  localparam int unsigned LS  = 16;
  localparam int unsigned SAW = 12;

  typedef logic [LS-1:0][DW-1:0]   line_t;
  typedef logic [LS-1:0][DW/8-1:0] strb_t;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [11:0] base;
    int          lat;
    logic [63:0] wmul;
    logic [15:0] zmask;
    logic [15:0] hmask;
    logic        perturb;
    string       tag;
  } vec_t;

  logic           clk;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [AW-1:0]  req_addr;
  logic           req_write;
  line_t          req_wdata;
  strb_t          req_wstrb;
  logic           resp_valid;
  line_t          resp_rdata;
  logic           sram_en;
  logic           sram_we;
  logic [SAW-1:0] sram_addr;
  logic [DW-1:0]  sram_wdata;
  logic [DW/8-1:0] sram_wstrb;
  logic [DW-1:0]  sram_rdata;

  logic [DW-1:0]  mem     [0:(1<<SAW)-1];
  logic [DW-1:0]  exp_mem [0:(1<<SAW)-1];
  logic           bd_en;
  logic [SAW-1:0] bd_addr;
  logic [DW-1:0]  bd_data;

  int checks = 0;
  int errors = 0;

  bulk_memory_controller #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .LINE_SIZE(LS),
    .SRAM_ADDR_W(SAW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_write(req_write),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .sram_en(sram_en),
    .sram_we(sram_we),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .sram_wstrb(sram_wstrb),
    .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM, read data one cycle after access; backdoor for preload.
  always @(posedge clk) begin
    if (bd_en) begin
      mem[bd_addr] <= bd_data;
    end else if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < DW/8; b++)
          if (sram_wstrb[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic line_t exp_line(input logic [11:0] base);
    line_t l;
    for (int k = 0; k < LS; k++) l[k] = exp_mem[12'(int'(base) + k)];
    return l;
  endfunction

  task automatic apply_write_model(input logic [11:0] base, input line_t wd, input strb_t ws, input int nbeats);
    for (int k = 0; k < nbeats; k++)
      for (int b = 0; b < DW/8; b++)
        if (ws[k][b]) exp_mem[12'(int'(base) + k)][8*b +: 8] = wd[k][8*b +: 8];
  endtask

  // One complete transaction with per-beat SRAM traffic checks and latency.
  task automatic run_txn(input logic wr, input logic [63:0] addr, input line_t wd, input strb_t ws,
                         input logic [11:0] base, input int exp_lat, input logic perturb, input string tag);
    int lat, beats, aerr, werr, rerr;
    line_t el;
    lat = -1; beats = 0; aerr = 0; werr = 0; rerr = 0;
    el = exp_line(base);
    @(negedge clk);
    check({tag, "_ready_idle"}, req_ready, 1);
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd; req_wstrb = ws;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (perturb) begin
      req_addr = ~addr; req_wdata = ~wd; req_wstrb = ~ws; req_write = ~wr;
    end
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (sram_en) begin
        if (beats >= LS) begin
          aerr++;
        end else begin
          if (sram_addr !== 12'(int'(base) + beats)) aerr++;
          if (wr) begin
            if (sram_we !== (|ws[beats]) || sram_wdata !== wd[beats] || sram_wstrb !== ws[beats]) werr++;
          end else if (sram_we !== 1'b0 || sram_wstrb !== '0) begin
            werr++;
          end
        end
        beats++;
      end
      if (req_ready !== 1'b0) rerr++;
      if (resp_valid === 1'b1) lat = n;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_beats"}, beats, LS);
    check({tag, "_addr_errs"}, aerr, 0);
    check({tag, "_we_data_errs"}, werr, 0);
    check({tag, "_busy_ready_errs"}, rerr, 0);
    if (wr) apply_write_model(base, wd, ws, LS);
    else    check({tag, "_rdata"}, resp_rdata, el);
    @(negedge clk);
    check({tag, "_resp_one_cycle"}, resp_valid, 0);
    check({tag, "_ready_after"}, req_ready, 1);
  endtask

  // Start a transaction, then assert reset while beat 7 is on the SRAM port.
  task automatic reset_at_beat7(input logic wr, input logic [63:0] addr, input logic [11:0] base,
                                input line_t wd, input string tag);
    int found, bad;
    strb_t ws;
    ws = '1;
    found = 0; bad = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd; req_wstrb = ws;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int n = 0; n < 30 && found == 0; n++) begin
      @(negedge clk);
      if (sram_en === 1'b1 && sram_addr === 12'(int'(base) + 7)) found = 1;
    end
    check({tag, "_reached_beat7"}, found, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after_rst"}, req_ready, 1);
    check({tag, "_no_resp_after_rst"}, resp_valid, 0);
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || sram_en !== 1'b0) bad++;
    end
    check({tag, "_quiet_after_rst"}, bad, 0);
    if (wr) apply_write_model(base, wd, ws, 7);
  endtask

  vec_t  vecs [9];
  line_t wd, l1, l2;
  strb_t ws;
  logic [11:0] lines [5];

  initial begin
    int acc, rsp, rerr, serr;
    int acc_cyc [4];
    int rsp_cyc [4];

    vecs[0] = '{1'b0, 64'h100,          12'h020, 18, 64'h0, 16'h0, 16'h0, 1'b0, "rd_aligned"};
    vecs[1] = '{1'b0, 64'h13F,          12'h020, 18, 64'h0, 16'h0, 16'h0, 1'b0, "rd_unaligned"};
    vecs[2] = '{1'b0, 64'h8000_0100,    12'h020, 18, 64'h0, 16'h0, 16'h0, 1'b0, "rd_upper_wrap"};
    vecs[3] = '{1'b1, 64'h80,           12'h010, 17, 64'h1111_1111_1111_1111, 16'h0008, 16'h0020, 1'b0, "wr_strobe"};
    vecs[4] = '{1'b0, 64'h80,           12'h010, 18, 64'h0, 16'h0, 16'h0, 1'b0, "rd_strobe_back"};
    vecs[5] = '{1'b1, 64'h200,          12'h040, 17, 64'h0123_4567_89AB_CDEF, 16'h0, 16'h0, 1'b1, "wr_perturb"};
    vecs[6] = '{1'b0, 64'h23C,          12'h040, 18, 64'h0, 16'h0, 16'h0, 1'b1, "rd_perturb"};
    vecs[7] = '{1'b0, 64'hFFF8,         12'hFF0, 18, 64'h0, 16'h0, 16'h0, 1'b0, "rd_top_line"};
    vecs[8] = '{1'b0, 64'h1_0000_7FC0,  12'hFF0, 18, 64'h0, 16'h0, 16'h0, 1'b0, "rd_top_wrap"};

    lines[0] = 12'h010; lines[1] = 12'h020; lines[2] = 12'h040; lines[3] = 12'h060; lines[4] = 12'hFF0;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0; req_wstrb = '0;
    bd_en = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < (1 << SAW); i++) exp_mem[i] = 'x;

    // Preload the lines touched by the test while the DUT is held in reset.
    for (int li = 0; li < 5; li++) begin
      for (int k = 0; k < LS; k++) begin
        @(negedge clk);
        bd_en = 1'b1;
        bd_addr = 12'(int'(lines[li]) + k);
        bd_data = (lines[li] == 12'h020) ? 64'(32'hA000 + k) : (64'hC0DE_0000_0000_0000 | 64'(int'(lines[li]) + k));
        exp_mem[bd_addr] = bd_data;
      end
    end
    @(negedge clk);
    bd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_sram_en", sram_en, 0);
    check("rst_sram_we", sram_we, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_sram_wdata", sram_wdata, 0);
    check("rst_sram_wstrb", sram_wstrb, 0);
    check("rst_resp_rdata", resp_rdata, 0);

    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < LS; k++) begin
        wd[k] = vecs[i].wmul * 64'(k);
        ws[k] = vecs[i].zmask[k] ? 8'h00 : (vecs[i].hmask[k] ? 8'h0F : 8'hFF);
      end
      run_txn(vecs[i].wr, vecs[i].addr, wd, ws, vecs[i].base, vecs[i].lat, vecs[i].perturb, vecs[i].tag);
      if (i == 0) begin
        check("rd_aligned_word0", resp_rdata[0], 64'hA000);
        check("rd_aligned_word15", resp_rdata[15], 64'hA00F);
      end
      if (i == 4) begin
        check("strobe_word3_unchanged", resp_rdata[3], 64'hC0DE_0000_0000_0013);
        check("strobe_word4_full", resp_rdata[4], 64'h4444_4444_4444_4444);
        check("strobe_word5_low_half", resp_rdata[5], 64'hC0DE_0000_5555_5555);
      end
    end

    // Back-to-back reads with req_valid held high across both.
    l1 = exp_line(12'h020);
    l2 = exp_line(12'h040);
    acc = 0; rsp = 0; rerr = 0; serr = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h100; req_wdata = '0; req_wstrb = '0;
    for (int n = 0; n < 45; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 1) req_addr = 64'h200;
      if (acc == 2) req_valid = 1'b0;
      if (req_valid === 1'b1 && req_ready === 1'b1) begin
        if (acc < 4) acc_cyc[acc] = n;
        acc++;
      end
      if (resp_valid === 1'b1) begin
        if (rsp < 4) rsp_cyc[rsp] = n;
        rsp++;
      end
      if (n >= 1 && n <= 18 && req_ready !== 1'b0) rerr++;
      if (n >= 18 && n <= 21 && resp_rdata !== l1) serr++;
      if (n == 37) check("b2b_second_rdata", resp_rdata, l2);
    end
    check("b2b_accepts", acc, 2);
    check("b2b_resps", rsp, 2);
    check("b2b_accept2_cycle", acc_cyc[1], 19);
    check("b2b_resp1_cycle", rsp_cyc[0], 18);
    check("b2b_resp2_cycle", rsp_cyc[1], 37);
    check("b2b_busy_ready_errs", rerr, 0);
    check("b2b_rdata_hold_errs", serr, 0);

    // Reset in the middle of a read, then of a write, then verify the write.
    reset_at_beat7(1'b0, 64'h100, 12'h020, '0, "rst_mid_read");
    for (int k = 0; k < LS; k++) wd[k] = 64'hDEAD_0000_0000_0000 + 64'(k);
    reset_at_beat7(1'b1, 64'h300, 12'h060, wd, "rst_mid_write");
    run_txn(1'b0, 64'h300, '0, '0, 12'h060, 18, 1'b0, "rd_after_rst_write");
    check("rst_write_word6_written", resp_rdata[6], 64'hDEAD_0000_0000_0006);
    check("rst_write_word7_untouched", resp_rdata[7], 64'hC0DE_0000_0000_0067);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
